bsh_norm32: RTL and testbench

Iterative 32-bit normalizer that recovers the shift amount the barrel shifter would need. It accepts a word over a valid/ready handshake and, in 5 binary-search steps, shifts the word until its MSB (or LSB) is 1. It returns the normalized word and the 5-bit shift count that was applied. It sits on the decode side of `bsh_32`: shifting `data_out` back by `sh` in the opposite direction reproduces `data_in` exactly, for any non-zero input.

---
 rtl/bsh_norm32.sv | 143 ++++++++++++++
 tb/tb_bsh_norm32.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsh_norm32.sv
// rtl/bsh_norm32.sv - iterative 32-bit normalizer (leading/trailing zero count with shift)
//
// Normalizes a 32-bit word with a 5-step binary search, one step per cycle.
// dir=0 shifts left until bit 31 is set. dir=1 shifts right until bit 0 is set.
// It returns the normalized word and the total shift applied. Shifting
// data_out back by sh in the opposite direction recovers data_in for any
// non-zero input.
//
// Optional feature: define BSH_NORM_ZERO_BYPASS_EN to collapse the search for an
// all-zero word to a single step.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   data_in/dir valid
//   in_ready   out  1   block idle and able to accept a word
//   data_in    in   32  word to normalize
//   dir        in   1   0: toward MSB (shift left), 1: toward LSB (shift right)
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   data_out   out  32  normalized word
//   sh         out  5   shift count applied
//   zero       out  1   input word was zero
module bsh_norm32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic        dir,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [4:0]  sh,
  output logic        zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] work_q;
  logic [4:0]  sh_q;
  logic        zero_q;
  logic        dir_q;
  logic [2:0]  k_q;
  logic        in_ready_q;
  logic        out_valid_q;

  // One binary-search step: the step width 2^k is also the weight of sh[k].
  logic [4:0]  step_amt;
  logic [31:0] lo_mask;
  logic [31:0] hi_mask;
  logic        step_take;
  logic [31:0] work_d;
  logic [4:0]  sh_d;
  logic        last_step;

  always_comb begin
    step_amt  = 5'd1 << k_q;
    lo_mask   = (32'h1 << step_amt) - 32'h1;
    hi_mask   = ~(32'hFFFF_FFFF >> step_amt);
    step_take = dir_q ? ((work_q & lo_mask) == 32'h0)
                      : ((work_q & hi_mask) == 32'h0);
    work_d    = work_q;
    sh_d      = sh_q;
    if (step_take) begin
      work_d = dir_q ? (work_q >> step_amt) : (work_q << step_amt);
      sh_d   = sh_q | step_amt;
    end
    last_step = (k_q == 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      work_q      <= 32'h0;
      sh_q        <= 5'd0;
      zero_q      <= 1'b0;
      dir_q       <= 1'b0;
      k_q         <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            work_q     <= data_in;
            dir_q      <= dir;
            sh_q       <= 5'd0;
            zero_q     <= 1'b0;
            k_q        <= 3'd4;
            state_q    <= S_BUSY;
            in_ready_q <= 1'b0;
`ifdef BSH_NORM_ZERO_BYPASS_EN
            // A zero word would take every step anyway: preload steps 4..1
            // and run only the k=0 step, which still sets sh[0] and zero.
            if (data_in == 32'h0) begin
              sh_q <= 5'b11110;
              k_q  <= 3'd0;
            end
`endif
          end
        end
        S_BUSY: begin
          work_q <= work_d;
          sh_q   <= sh_d;
          if (last_step) begin
            // Shifting never turns a non-zero word into zero, so the working
            // value tells us whether the captured word was zero.
            zero_q      <= (work_q == 32'h0);
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q - 3'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = work_q;
  assign sh        = sh_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bsh_norm32.sv
// tb/tb_bsh_norm32.sv - directed and round-trip bench for bsh_norm32
module tb_bsh_norm32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [4:0]  sh;
  logic        zero;

  int checks;
  int errors;

  bsh_norm32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sh        (sh),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT_LIMIT = 20;

`ifdef BSH_NORM_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 5;
`endif

  // Reference: count leading/trailing zeros bit by bit.
  function automatic int ref_clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int ref_ctz(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 32;
  endfunction

  // Presents one word, returns number of edges after the accept edge until
  // out_valid is seen (LAT_LIMIT if it never appears).
  task automatic start_txn(input logic [31:0] d, input logic dr, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in  = d;
    dir      = dr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = 32'hDEAD_BEEF;
    dir      = ~dr;
    lat = 0;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic end_txn();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 32'h0 ||
        sh !== 5'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h sh=%0d zero=%b, required 1 0 0 0 0",
               in_ready, out_valid, data_out, sh, zero);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clz();
    int lat;
    start_txn(32'h18A0_0000, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL clz_latency: got %0d required 5", lat);
    end
    checks++;
    if (sh !== 5'd3 || data_out !== 32'hC500_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL clz_result: sh=%0d data=%h zero=%b, required 3 c5000000 0", sh, data_out, zero);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clz_no_overlap: in_ready=%b with out_valid, required 0", in_ready);
    end
    end_txn();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clz_release: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ctz();
    int lat;
    start_txn(32'h00FF_0000, 1'b1, lat);
    checks++;
    if (lat !== 5 || sh !== 5'd16 || data_out !== 32'h0000_00FF || zero !== 1'b0) begin
      errors++;
      $display("FAIL ctz_result: lat=%0d sh=%0d data=%h zero=%b, required 5 16 000000ff 0",
               lat, sh, data_out, zero);
    end
    end_txn();
    start_txn(32'h0000_0001, 1'b0, lat);
    checks++;
    if (lat !== 5 || sh !== 5'd31 || data_out !== 32'h8000_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL clz_one: lat=%0d sh=%0d data=%h zero=%b, required 5 31 80000000 0",
               lat, sh, data_out, zero);
    end
    end_txn();
  endtask

  task automatic test_zero();
    int lat;
    for (int d = 0; d < 2; d++) begin
      start_txn(32'h0, d[0], lat);
      checks++;
      if (lat !== ZERO_LAT || sh !== 5'd31 || data_out !== 32'h0 || zero !== 1'b1) begin
        errors++;
        $display("FAIL zero_dir%0d: lat=%0d sh=%0d data=%h zero=%b, required %0d 31 0 1",
                 d, lat, sh, data_out, zero, ZERO_LAT);
      end
      end_txn();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_txn(32'h18A0_0000, 1'b0, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      data_in  = 32'h1234_5670 + i;
      dir      = i[1];
      out_ready = 1'b0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sh !== 5'd3 ||
          data_out !== 32'hC500_0000 || zero !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad);
    end
    end_txn();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 32'hC500_0000) begin
      errors++;
      $display("FAIL backpressure_release: rdy=%b vld=%b data=%h, required 1 0 c5000000",
               in_ready, out_valid, data_out);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in  = 32'h18A0_0000;
    dir      = 1'b0;
    @(posedge clk); #1;            // E0
    in_valid = 1'b0;
    @(posedge clk);                // E1
    @(posedge clk);                // E2
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 32'h0 ||
        sh !== 5'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: rdy=%b vld=%b data=%h sh=%0d zero=%b, required 1 0 0 0 0",
               in_ready, out_valid, data_out, sh, zero);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_result: out_valid=%b, required 0", out_valid);
    end
    start_txn(32'h00FF_0000, 1'b1, lat);
    checks++;
    if (lat !== 5 || sh !== 5'd16 || data_out !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL reset_follow: lat=%0d sh=%0d data=%h, required 5 16 000000ff", lat, sh, data_out);
    end
    end_txn();
  endtask

  task automatic test_round_trip();
    int lat;
    int n;
    logic [31:0] d;
    logic        dr;
    logic [31:0] exp_data;
    logic [31:0] back;
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      // Vary the zero runs so small and large counts both appear.
      d = d >> $urandom_range(0, 31);
      d = d << $urandom_range(0, 31);
      if (d == 32'h0) d = 32'h1 << $urandom_range(0, 31);
      dr = i[0];
      n = dr ? ref_ctz(d) : ref_clz(d);
      exp_data = dr ? (d >> n) : (d << n);
      start_txn(d, dr, lat);
      back = dr ? (data_out << sh) : (data_out >> sh);
      checks++;
      if (lat !== 5 || sh !== n[4:0] || data_out !== exp_data || zero !== 1'b0 ||
          back !== d || (dr ? data_out[0] : data_out[31]) !== 1'b1) begin
        errors++;
        $display("FAIL round_trip %0d: in=%h dir=%b lat=%0d sh=%0d data=%h zero=%b, required 5 %0d %h 0",
                 i, d, dr, lat, sh, data_out, zero, n, exp_data);
      end
      end_txn();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = 32'h0;
    dir       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_clz();
    test_ctz();
    test_zero();
    test_backpressure();
    test_reset_abort();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overlap watchdog: in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL overlap: in_ready=1 out_valid=1, required not both");
      end
    end
  end

endmodule
